// File: rtl/card_deal_arbiter.sv
// Round-robin card request arbiter between player and dealer in front of a fixed-latency card datapath.
// Optional burn card after reset/reshuffle: define DEAL_BURN_CARD_EN.
module card_deal_arbiter #(
    parameter int CARD_LAT  = 2,
    parameter int DECK_SIZE = 52
) (
    input  logic       clk_arb_i,
    input  logic       rst_arb_i,
    input  logic       req_player_i,
    input  logic       req_dealer_i,
    input  logic       reshuffle_i,
    input  logic [7:0] card_dp_i,
    output logic       req_card_state_o,
    output logic [7:0] card_o,
    output logic       ack_player_o,
    output logic       ack_dealer_o,
    output logic       busy_o,
    output logic       deck_empty_o,
    output logic [5:0] cards_dealt_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] DELIVER = 3'd3;
    localparam logic [2:0] EMPTY   = 3'd4;
`ifdef DEAL_BURN_CARD_EN
    localparam logic [2:0] BURN    = 3'd5;
`endif

    logic [2:0] state;
    logic [3:0] wait_cnt;
    logic       grant_dealer;
    logic       last_dealer;
    logic       rs_pend;
    logic       ack_p;
    logic       ack_d;
    logic [7:0] card_q;
    logic [5:0] dealt;
    logic       pick_dealer;
    logic       any_req;
`ifdef DEAL_BURN_CARD_EN
    logic       burn_pend;
    logic       burning;
`endif

    // Dealer wins only when alone or when the player was served last.
    always_comb begin
        any_req     = req_player_i | req_dealer_i;
        pick_dealer = req_dealer_i & (~req_player_i | ~last_dealer);
    end

    always_ff @(posedge clk_arb_i) begin
        if (rst_arb_i) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            grant_dealer <= 1'b0;
            last_dealer  <= 1'b1;
            rs_pend      <= 1'b0;
            ack_p        <= 1'b0;
            ack_d        <= 1'b0;
            card_q       <= 8'h00;
            dealt        <= '0;
`ifdef DEAL_BURN_CARD_EN
            burn_pend    <= 1'b1;
            burning      <= 1'b0;
`endif
        end else begin
            ack_p <= 1'b0;
            ack_d <= 1'b0;
            case (state)
                IDLE: begin
                    if (reshuffle_i) begin
                        dealt <= '0;
`ifdef DEAL_BURN_CARD_EN
                        burn_pend <= 1'b1;
                    end else if (burn_pend) begin
                        state <= BURN;
`endif
                    end else if (any_req) begin
                        grant_dealer <= pick_dealer;
                        last_dealer  <= pick_dealer;
                        state        <= ISSUE;
                    end
                end
`ifdef DEAL_BURN_CARD_EN
                BURN: begin
                    burning   <= 1'b1;
                    burn_pend <= 1'b0;
                    if (reshuffle_i) rs_pend <= 1'b1;
                    state <= ISSUE;
                end
`endif
                ISSUE: begin
                    if (reshuffle_i) rs_pend <= 1'b1;
                    wait_cnt <= 4'(CARD_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (reshuffle_i) rs_pend <= 1'b1;
                    // Card is captured on the last WAIT edge so card_o is valid alongside the ack.
                    if (wait_cnt == 4'd0) begin
                        state <= DELIVER;
                        dealt <= dealt + 6'd1;
`ifdef DEAL_BURN_CARD_EN
                        if (!burning) begin
`else
                        begin
`endif
                            card_q <= card_dp_i;
                            ack_p  <= ~grant_dealer;
                            ack_d  <= grant_dealer;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DELIVER: begin
`ifdef DEAL_BURN_CARD_EN
                    burning <= 1'b0;
`endif
                    if (rs_pend || reshuffle_i) begin
                        dealt   <= '0;
                        rs_pend <= 1'b0;
                        state   <= IDLE;
`ifdef DEAL_BURN_CARD_EN
                        burn_pend <= 1'b1;
`endif
                    end else if (dealt == 6'(DECK_SIZE)) begin
                        state <= EMPTY;
                    end else begin
                        state <= IDLE;
                    end
                end
                EMPTY: begin
                    if (reshuffle_i) begin
                        dealt <= '0;
                        state <= IDLE;
`ifdef DEAL_BURN_CARD_EN
                        burn_pend <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_card_state_o = (state == ISSUE);
    assign busy_o           = (state != IDLE) && (state != EMPTY);
    assign deck_empty_o     = (state == EMPTY);
    assign ack_player_o     = ack_p;
    assign ack_dealer_o     = ack_d;
    assign card_o           = card_q;
    assign cards_dealt_o    = dealt;

endmodule

// File: doc/card_deal_arbiter.md
CARD_DEAL_ARBITER -- requirements
Module: card_deal_arbiter

Interface
REQ-001 SHALL have parameter CARD_LAT, default 2: clocks from the datapath request pulse to a valid card at card_dp_i; legal range 1..15.
REQ-002 SHALL have parameter DECK_SIZE, default 52: cards dealt before the deck is exhausted; legal range 1..63.
REQ-003 SHALL have port clk_arb_i, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_arb_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_player_i, input, 1: player card request, level, held until ack.
REQ-006 SHALL have port req_dealer_i, input, 1: dealer card request, level, held until ack.
REQ-007 SHALL have port reshuffle_i, input, 1: clears the deal count; one-cycle pulse.
REQ-008 SHALL have port card_dp_i, input, 8: card code returned by the card datapath.
REQ-009 SHALL have port req_card_state_o, output, 1: one-cycle request pulse to the card datapath.
REQ-010 SHALL have port card_o, output, 8: last delivered card, held until the next delivery.
REQ-011 SHALL have port ack_player_o, output, 1: one-cycle pulse, card_o valid for the player.
REQ-012 SHALL have port ack_dealer_o, output, 1: one-cycle pulse, card_o valid for the dealer.
REQ-013 SHALL have port busy_o, output, 1: high in any state other than IDLE and EMPTY.
REQ-014 SHALL have port deck_empty_o, output, 1: high while in EMPTY.
REQ-015 SHALL have port cards_dealt_o, output, 6: count of datapath requests completed since reset or reshuffle.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DELIVER, EMPTY, and BURN if configured.
REQ-017 SHALL, in IDLE with any request asserted and no reshuffle, register the grant and go to ISSUE.
REQ-018 SHALL assert req_card_state_o for exactly the single ISSUE cycle, then go to WAIT.
REQ-019 SHALL stay in WAIT for exactly CARD_LAT cycles, then go to DELIVER.
REQ-020 SHALL, in DELIVER, load card_o from card_dp_i, pulse only the granted requester's ack, and increment cards_dealt_o.
REQ-021 SHALL, after DELIVER, go to EMPTY if cards_dealt_o equals DECK_SIZE, else to IDLE.
REQ-022 SHALL assert the ack 2+CARD_LAT clocks after the IDLE cycle that sampled the request (4 at default).
REQ-023 SHALL grant round-robin: on simultaneous requests, grant the requester not granted last; after reset, the player has priority.
REQ-024 SHALL complete a granted transaction even if its request deasserts mid-flight; the ack still pulses.
REQ-025 SHALL never issue a datapath request and SHALL ignore all requests while in EMPTY.
REQ-026 SHALL, on reshuffle_i in IDLE or EMPTY, clear cards_dealt_o next cycle and go to IDLE; reshuffle wins over a same-cycle request.
REQ-027 SHALL, on reshuffle_i during ISSUE, WAIT or DELIVER, set a pending flag and apply the clear on the cycle after DELIVER, overriding the EMPTY transition.
REQ-028 SHALL, on simultaneous req_player_i and req_dealer_i deasserting before grant, issue nothing.

Reset
REQ-029 SHALL, with rst_arb_i high at a clock edge, go to IDLE and set these outputs to 0: req_card_state_o, ack_player_o, ack_dealer_o, busy_o, deck_empty_o, card_o=8'h00, cards_dealt_o=0.
REQ-030 SHALL, on reset, clear the pending-reshuffle flag and reset the round-robin pointer to player priority.
REQ-031 SHALL abandon any in-flight transaction on reset mid-operation, with no ack.

Configuration
REQ-032 SHALL, with macro DEAL_BURN_CARD_EN defined, enter BURN after reset or any applied reshuffle.
REQ-033 SHALL, in BURN, run one ISSUE/WAIT/DELIVER sequence with no ack and card_o unchanged, increment cards_dealt_o, and hold requests until done.
REQ-034 SHALL, without DEAL_BURN_CARD_EN, omit BURN entirely; the first request after reset is dealt directly.

Verification
REQ-035 SHALL verify: reset, then req_player_i=1 at cycle 0 -> req_card_state_o pulse at cycle 1, ack_player_o at cycle 4, card_o=card_dp_i, cards_dealt_o=1.
REQ-036 SHALL verify: both requests held -> grants player, dealer, player alternately; each ack is a single cycle.
REQ-037 SHALL verify: DECK_SIZE=52 with 52 player deals -> deck_empty_o=1; the 53rd request gets no req_card_state_o; reshuffle_i -> cards_dealt_o=0 and IDLE.
REQ-038 SHALL verify: reshuffle_i during WAIT -> deal completes with an ack, then cards_dealt_o=0 the cycle after DELIVER.
REQ-039 SHALL verify: with DEAL_BURN_CARD_EN -> after reset, one unacked req_card_state_o pulse, cards_dealt_o=1, then normal deals.
REQ-040 SHALL verify: rst_arb_i asserted during WAIT -> no ack, and all outputs are 0 on the next cycle.
